// File: rtl/window_sched_pkg.sv
// -----------------------------------------------------------------------------
// window_sched_pkg
// Shared definitions for the window scheduler: FSM state encoding, the number
// of left-edge pad advances issued before each line, and a helper that sizes
// the wrap counters.
// -----------------------------------------------------------------------------
package window_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_PASS = 3'd2,
        ST_POST = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    // Left-edge pad advances per line (half of the 5-tap window).
    localparam int PRE_PADS = 2;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_bits(input int max_val);
        if (max_val < 1) begin
            return 1;
        end else begin
            return $clog2(max_val + 1);
        end
    endfunction

endpackage

// File: rtl/window_sched_cnt.sv
// -----------------------------------------------------------------------------
// window_sched_cnt
// Parameterised wrap counter: counts 0..MAX on each inc and returns to 0 after
// MAX, so the scheduler counters never overflow.
// Ports:
//   clock  in   single clock
//   reset  in   synchronous active-high clear
//   inc    in   count enable
//   count  out  current count (BITS wide)
// -----------------------------------------------------------------------------
module window_sched_cnt
    import window_sched_pkg::*;
#(
    parameter int MAX  = 1,
    parameter int BITS = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            inc,
    output logic [BITS-1:0] count
);

    localparam logic [BITS-1:0] MAX_V = BITS'(MAX);

    logic [BITS-1:0] count_r;

    // Count register: wraps to zero after reaching MAX.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= {BITS{1'b0}};
        end else if (inc) begin
            if (count_r == MAX_V) begin
                count_r <= {BITS{1'b0}};
            end else begin
                count_r <= count_r + BITS'(1);
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/window_sched.sv
// -----------------------------------------------------------------------------
// window_sched
// Feeds a raster pixel stream through a 5-tap horizontal window datapath,
// inserting edge pads at each line start/end and trimming the datapath
// pipeline lag so exactly WIDTH filtered pixels leave per line.
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   start                   pulse arming one frame (ignored while busy)
//   s_data/s_valid/s_ready  upstream pixel stream
//   dp_din/dp_validin       drive to the window datapath (validin = advance)
//   dp_dout                 registered datapath result
//   m_data/m_valid/m_ready  filtered output stream
//   m_sof/m_eol             first pixel of frame / last pixel of line
//   busy/frame_done         frame in progress / end-of-frame pulse
// Build option: WINDOW_SCHED_ZERO_PAD_EN makes the edge pads zero instead of
// replicating the edge pixels; ports and timing are unchanged.
// -----------------------------------------------------------------------------
module window_sched
    import window_sched_pkg::*;
#(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DP_LAG = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] dp_din,
    output logic       dp_validin,
    input  logic [7:0] dp_dout,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sof,
    output logic       m_eol,
    output logic       busy,
    output logic       frame_done
);

    localparam int ADV_MAX = WIDTH + 1 + DP_LAG;
    localparam int AW      = cnt_bits(ADV_MAX);
    localparam int CW      = cnt_bits(WIDTH - 1);
    localparam int RW      = cnt_bits(HEIGHT - 1);

    localparam logic [AW-1:0] ADV_PRE_LAST  = AW'(PRE_PADS - 1);
    localparam logic [AW-1:0] ADV_FIRST_OUT = AW'(PRE_PADS + DP_LAG);
    localparam logic [AW-1:0] ADV_LAST      = AW'(ADV_MAX);
    localparam logic [CW-1:0] COL_LAST      = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(HEIGHT - 1);

    state_e          state_r;
    logic [7:0]      last_pix_r;
    logic            m_valid_r;
    logic            m_sof_r;
    logic            m_eol_r;
    logic            frame_done_r;

    logic [AW-1:0]   adv_cnt_s;
    logic [CW-1:0]   col_cnt_s;
    logic [RW-1:0]   row_cnt_s;
    logic            adv_ok_s;
    logic            advance_s;
    logic            s_ready_s;
    logic [7:0]      dp_din_s;
    logic [7:0]      pre_pad_s;
    logic [7:0]      post_pad_s;
    logic            accept_s;
    logic            pre_done_s;
    logic            post_done_s;
    logic            out_win_s;

`ifdef WINDOW_SCHED_ZERO_PAD_EN
    assign pre_pad_s  = 8'd0;
    assign post_pad_s = 8'd0;
`else
    assign pre_pad_s  = s_data;
    assign post_pad_s = last_pix_r;
`endif

    // The datapath may only shift while no output is stuck waiting, so
    // dp_dout stays equal to the pending m_data.
    assign adv_ok_s = !(m_valid_r && !m_ready);

    // Per-state drive of the datapath and the upstream ready.
    always_comb begin
        s_ready_s = 1'b0;
        advance_s = 1'b0;
        dp_din_s  = 8'd0;
        case (state_r)
            ST_PRE: begin
                // Pads follow the line's first pixel, so wait until it is offered.
                advance_s = s_valid && adv_ok_s;
                dp_din_s  = pre_pad_s;
            end
            ST_PASS: begin
                s_ready_s = adv_ok_s;
                advance_s = s_valid && adv_ok_s;
                dp_din_s  = s_data;
            end
            ST_POST: begin
                advance_s = adv_ok_s;
                dp_din_s  = post_pad_s;
            end
            default: begin
                s_ready_s = 1'b0;
                advance_s = 1'b0;
                dp_din_s  = 8'd0;
            end
        endcase
    end

    assign accept_s    = (state_r == ST_PASS) && advance_s;
    assign pre_done_s  = (state_r == ST_PRE) && advance_s && (adv_cnt_s == ADV_PRE_LAST);
    assign post_done_s = (state_r == ST_POST) && advance_s && (adv_cnt_s == ADV_LAST);
    assign out_win_s   = (adv_cnt_s >= ADV_FIRST_OUT);

    window_sched_cnt #(.MAX(ADV_MAX), .BITS(AW)) u_adv_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (advance_s),
        .count (adv_cnt_s)
    );

    window_sched_cnt #(.MAX(WIDTH - 1), .BITS(CW)) u_col_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (accept_s),
        .count (col_cnt_s)
    );

    window_sched_cnt #(.MAX(HEIGHT - 1), .BITS(RW)) u_row_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (post_done_s),
        .count (row_cnt_s)
    );

    // Frame sequencing, right-edge pixel capture and the end-of-frame pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_pix_r   <= 8'd0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (pre_done_s) begin
                        state_r <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (accept_s) begin
                        last_pix_r <= s_data;
                        if (col_cnt_s == COL_LAST) begin
                            state_r <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (post_done_s) begin
                        state_r <= (row_cnt_s == ROW_LAST) ? ST_DONE : ST_PRE;
                    end
                end
                ST_DONE: begin
                    // The final pixel is pending here; finish once it is taken.
                    if (!m_valid_r || m_ready) begin
                        frame_done_r <= 1'b1;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output qualifiers: an advance inside the output window presents the
    // result on the next cycle; a pending output holds until m_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_sof_r   <= 1'b0;
            m_eol_r   <= 1'b0;
        end else if (advance_s) begin
            m_valid_r <= out_win_s;
            m_sof_r   <= (adv_cnt_s == ADV_FIRST_OUT) && (row_cnt_s == {RW{1'b0}});
            m_eol_r   <= (adv_cnt_s == ADV_LAST);
        end else if (m_ready) begin
            m_valid_r <= 1'b0;
            m_sof_r   <= 1'b0;
            m_eol_r   <= 1'b0;
        end else begin
            m_valid_r <= m_valid_r;
            m_sof_r   <= m_sof_r;
            m_eol_r   <= m_eol_r;
        end
    end

    assign s_ready    = s_ready_s;
    assign dp_validin = advance_s;
    assign dp_din     = dp_din_s;
    assign m_data     = dp_dout;
    assign m_valid    = m_valid_r;
    assign m_sof      = m_sof_r;
    assign m_eol      = m_eol_r;
    assign busy       = (state_r != ST_IDLE);
    assign frame_done = frame_done_r;

endmodule
